cap_token_sched: RTL and testbench
==================================

# cap_token_sched

Round-robin scheduler that shares one change-triggered capture register between several requesters. The register loads its data input whenever its 5-bit enable code changes. This block grants one requester at a time and drives the shared data bus. It then advances the 5-bit enable code exactly once per grant, so the register captures exactly one sample per grant. It sits between the requesting sub-blocks and the capture-register bank, and acknowledges each requester once its sample has been captured.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 1: width of each requester's sample and of the capture bus.
- HOLD_CYC, 2: cycles that en_code/cap_data are held stable after issue, before the ack; minimum 1.

- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until its ack.
- req_data  in  NUM_REQ*DATA_W  packed samples; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-cycle pulse to the granted requester when its capture is complete.
- en_code  out  5  enable code to the capture register; changes only on issue.
- cap_data  out  DATA_W  sample presented to the capture register.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in ISSUE and HOLD.

## Operation
- Reset values: req_ack=0, en_code=5'd0, cap_data=0, grant_id=0, busy=0, state=IDLE, round-robin pointer=0.
- FSM has three states: IDLE, ISSUE and HOLD.
- IDLE:
  - If any req_valid is set, the arbiter picks the winner.
  - Round-robin search starts at the pointer, which is the index after the last grant.
  - Next cycle: grant_id=winner, cap_data=req_data[winner] (latched internally), en_code=en_code+1, state goes to ISSUE.
- ISSUE (1 cycle): the capture register samples the new en_code/cap_data at the end of this cycle. State goes to HOLD and the hold counter loads HOLD_CYC-1.
- HOLD:
  - While the counter is nonzero, decrement it.
  - When it is zero, pulse req_ack[grant_id] for one cycle, set the pointer to grant_id+1 mod NUM_REQ, and return to IDLE.
- en_code arithmetic:
  - Increments mod 32 and wraps 31->0.
  - Every grant therefore changes en_code and toggles en_code[0].
  - The first grant after reset yields 5'd1.
  - en_code never changes except on issue.
- Once a grant is issued, it is committed:
  - If the winner drops req_valid or changes req_data mid-grant, cap_data is unaffected and the ack is still pulsed.
  - Requests from other requesters during busy wait; they are not lost.
- A requester must deassert or re-present req_valid in the cycle after its ack. If it stays high, it is treated as a new request and competes normally.
- When no requester is valid, the block idles with en_code frozen.

## Timing
- req_valid rises in IDLE at cycle T:
  - en_code/cap_data update at T+1.
  - The downstream captures at the edge ending T+1.
  - req_ack pulses at T+1+HOLD_CYC.
  - The next issue occurs no earlier than T+2+HOLD_CYC.
- Throughput is one grant per HOLD_CYC+2 cycles.
- Reset asserted mid-grant:
  - All outputs return to reset values immediately.
  - No ack is issued.
  - en_code returns to 0.
- Simultaneous requests are resolved in one cycle, and only one grant is active at a time.

## Configuration
- SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest valid index always wins and the pointer is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold reset_n=0 with all req_valid=1 -> en_code=0, req_ack=0, busy=0. Release -> first issue gives en_code=1, grant_id=0.
- Single request: NUM_REQ=4, HOLD_CYC=2, req_valid=4'b0100, data=1 at T -> en_code 0->1 and cap_data=1 at T+1; req_ack=4'b0100 at T+3, one cycle only.
- Round-robin fairness: all four requesters held valid -> grants in order 0,1,2,3,0; en_code 1,2,3,4,5; each ack one-hot.
- Wrap: 32 consecutive grants from one requester -> en_code reaches 31 then 0; bit 0 toggles on every grant; each grant is acked.
- Mid-grant changes: the winner drops valid and flips its data during HOLD -> cap_data unchanged, ack still pulses. Reset asserted in HOLD -> outputs clear immediately, no ack.
- SCHED_FIXED_PRIO_EN defined, req_valid=4'b1010 held -> requester 1 wins every grant while requester 3 waits.

Source files
------------

// File: rtl/cap_token_sched_if.sv
// Request/capture bundle shared by requesters, the scheduler and the capture bank.
// master drives requests; slave is the scheduler side.
interface cap_token_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [4:0]                en_code;
  logic [DATA_W-1:0]         cap_data;
  logic [GW-1:0]             grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_data,
    input  req_ack, en_code, cap_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ack, en_code, cap_data, grant_id, busy
  );
endinterface

// File: rtl/cap_token_sched.sv
// Round-robin grant of one change-triggered capture register; one en_code step per grant.
// SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module cap_token_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 1,
  parameter int HOLD_CYC = 2
) (
  input logic clk,
  input logic reset_n,
  cap_token_sched_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [4:0]        en_q;
  logic [DATA_W-1:0] cap_q;
  logic [GW-1:0]     gid_q;
  logic [HW-1:0]     cnt_q;
  logic [GW-1:0]     win;
  logic              hit;
  logic [DATA_W-1:0] win_data;
  logic              issue;
  logic              done;

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win = GW'(i);
        hit = 1'b1;
      end
    end
  end
`else
  logic [GW-1:0] ptr_q;

  // Closest valid requester at or after the pointer wins.
  always_comb begin
    int off;
    int best;
    win  = '0;
    hit  = 1'b0;
    off  = 0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
      if (bus.req_valid[i] && off < best) begin
        best = off;
        win  = GW'(i);
        hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (done) begin
      if (gid_q == GW'(NUM_REQ - 1)) ptr_q <= '0;
      else                           ptr_q <= gid_q + GW'(1);
    end
  end
`endif

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) win_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      en_q    <= '0;
      cap_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Sample is committed here; later request changes cannot disturb it.
      if (issue) begin
        en_q  <= en_q + 5'd1;
        cap_q <= win_data;
        gid_q <= win;
      end
      if (state_q == ISSUE) begin
        cnt_q <= HW'(HOLD_CYC - 1);
      end else if (state_q == HOLD && cnt_q != '0) begin
        cnt_q <= cnt_q - HW'(1);
      end
    end
  end

  assign bus.en_code  = en_q;
  assign bus.cap_data = cap_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.req_ack  = done ? (NUM_REQ'(1) << gid_q) : '0;
endmodule

// File: tb/tb_cap_token_sched.sv
// Self-checking bench for cap_token_sched: directed scenarios plus random traffic.
// Reference model works on grant timestamps and a pick-from-pointer search.
module tb_cap_token_sched;
  localparam int NR = 4;
  localparam int DW = 1;
  localparam int HC = 2;
  localparam int GW = $clog2(NR);

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  cap_token_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  cap_token_sched #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .HOLD_CYC(HC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(logic [NR-1:0] v, int p);
    int s;
    s = p;
`ifdef SCHED_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < NR; k++) begin
      if (v[(s + k) % NR]) return (s + k) % NR;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [NR*DW-1:0] d;
    d = NR*DW'($urandom);
    reset_n = 1'b0;
    bus.req_valid = '1;
    bus.req_data = d;
    repeat (3) step();
    checks++;
    if (bus.en_code !== 5'd0) begin
      errors++;
      $display("FAIL rst_en got %0d want 0", bus.en_code);
    end
    checks++;
    if (bus.req_ack !== '0) begin
      errors++;
      $display("FAIL rst_ack got %b want 0", bus.req_ack);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.grant_id !== '0 || bus.cap_data !== '0) begin
      errors++;
      $display("FAIL rst_gid_cap got %0d/%0h want 0/0",
               bus.grant_id, bus.cap_data);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.en_code !== 5'd1 || bus.grant_id !== GW'(0)) begin
      errors++;
      $display("FAIL first_issue got en=%0d gid=%0d want en=1 gid=0",
               bus.en_code, bus.grant_id);
    end
    checks++;
    if (bus.cap_data !== d[DW-1:0] || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_cap got %0h/%b want %0h/1",
               bus.cap_data, bus.busy, d[DW-1:0]);
    end
    bus.req_valid = '0;
    repeat (HC - 1) step();
    step();
    checks++;
    if (bus.req_ack !== NR'(1)) begin
      errors++;
      $display("FAIL first_ack got %b want %b", bus.req_ack, NR'(1));
    end
    step();
  endtask

  task automatic test_single();
    do_reset();
    step();
    bus.req_valid = 4'b0100;
    bus.req_data = 4'b0100;
    step();
    checks++;
    if (bus.en_code !== 5'd1 || bus.cap_data !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got en=%0d cap=%0h want en=1 cap=1",
               bus.en_code, bus.cap_data);
    end
    checks++;
    if (bus.grant_id !== GW'(2)) begin
      errors++;
      $display("FAIL single_gid got %0d want 2", bus.grant_id);
    end
    for (int k = 1; k < HC; k++) begin
      step();
      checks++;
      if (bus.req_ack !== '0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold got ack=%b busy=%b want 0/1",
                 bus.req_ack, bus.busy);
      end
    end
    step();
    checks++;
    if (bus.req_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack got %b want 0100", bus.req_ack);
    end
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.req_ack !== '0 || bus.busy !== 1'b0 || bus.en_code !== 5'd1) begin
        errors++;
        $display("FAIL single_idle got ack=%b busy=%b en=%0d want 0/0/1",
                 bus.req_ack, bus.busy, bus.en_code);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NR*DW-1:0] d;
    int p;
    int w;
    do_reset();
    d = NR*DW'($urandom);
    p = 0;
    bus.req_valid = '1;
    bus.req_data = d;
    for (int g = 1; g <= 5; g++) begin
      w = pick('1, p);
      p = (w + 1) % NR;
      step();
      checks++;
      if (bus.grant_id !== GW'(w) || bus.en_code !== 5'(g)) begin
        errors++;
        $display("FAIL rr_grant got gid=%0d en=%0d want gid=%0d en=%0d",
                 bus.grant_id, bus.en_code, w, g);
      end
      checks++;
      if (bus.cap_data !== d[w*DW +: DW]) begin
        errors++;
        $display("FAIL rr_cap got %0h want %0h",
                 bus.cap_data, d[w*DW +: DW]);
      end
      repeat (HC - 1) step();
      step();
      checks++;
      if (bus.req_ack !== (NR'(1) << w)) begin
        errors++;
        $display("FAIL rr_ack got %b want %b", bus.req_ack, NR'(1) << w);
      end
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.req_ack !== '0) begin
        errors++;
        $display("FAIL rr_idle got busy=%b ack=%b want 0/0",
                 bus.busy, bus.req_ack);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [4:0] e;
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data = '0;
    for (int g = 1; g <= 33; g++) begin
      e = 5'(g % 32);
      step();
      checks++;
      if (bus.en_code !== e || bus.en_code[0] !== e[0]) begin
        errors++;
        $display("FAIL wrap_en got %0d want %0d", bus.en_code, e);
      end
      repeat (HC - 1) step();
      step();
      checks++;
      if (bus.req_ack !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_ack got %b want 0001", bus.req_ack);
      end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_prio_pattern();
    int p;
    int w;
    do_reset();
    p = 0;
    bus.req_valid = 4'b1010;
    bus.req_data = 4'b1000;
    for (int g = 1; g <= 4; g++) begin
      w = pick(4'b1010, p);
      p = (w + 1) % NR;
      step();
      checks++;
      if (bus.grant_id !== GW'(w)) begin
        errors++;
        $display("FAIL prio_gid got %0d want %0d", bus.grant_id, w);
      end
      repeat (HC - 1) step();
      step();
      checks++;
      if (bus.req_ack !== (NR'(1) << w)) begin
        errors++;
        $display("FAIL prio_ack got %b want %b", bus.req_ack, NR'(1) << w);
      end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_mid_grant();
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_data = 4'b0010;
    step();
    checks++;
    if (bus.grant_id !== GW'(1) || bus.cap_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue got gid=%0d cap=%0h want 1/1",
               bus.grant_id, bus.cap_data);
    end
    step();
    bus.req_valid = '0;
    bus.req_data = '0;
    repeat (HC - 2) step();
    step();
    checks++;
    if (bus.req_ack !== 4'b0010 || bus.cap_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack got ack=%b cap=%0h want 0010/1",
               bus.req_ack, bus.cap_data);
    end
    step();
    bus.req_valid = 4'b1000;
    bus.req_data = 4'b1000;
    step();
    checks++;
    if (bus.grant_id !== GW'(pick(4'b1000, 2)) || bus.en_code !== 5'd2) begin
      errors++;
      $display("FAIL rst_mid_issue got gid=%0d en=%0d want 3/2",
               bus.grant_id, bus.en_code);
    end
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.en_code !== 5'd0 || bus.busy !== 1'b0 || bus.req_ack !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear got en=%0d busy=%b ack=%b want 0/0/0",
               bus.en_code, bus.busy, bus.req_ack);
    end
    checks++;
    if (bus.grant_id !== '0 || bus.cap_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_gid got %0d/%0h want 0/0",
               bus.grant_id, bus.cap_data);
    end
    for (int k = 0; k <= HC; k++) begin
      step();
      checks++;
      if (bus.req_ack !== '0) begin
        errors++;
        $display("FAIL rst_mid_noack got %b want 0", bus.req_ack);
      end
    end
    bus.req_valid = '0;
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.en_code !== 5'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got en=%0d busy=%b want 0/0",
               bus.en_code, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0]    pend;
    logic [NR-1:0]    eack;
    logic [NR-1:0]    ack_prev;
    logic [NR*DW-1:0] d;
    logic [4:0]       en;
    logic [DW-1:0]    cap;
    logic             ebusy;
    int next_free, ack_at, bstart, bend, gid, ptr;
    do_reset();
    pend = '0;
    d = '0;
    en = '0;
    cap = '0;
    gid = 0;
    ptr = 0;
    next_free = 0;
    ack_at = -1;
    bstart = -1;
    bend = -1;
    ack_prev = '0;
    for (int c = 0; c < 800; c++) begin
      eack = (c == ack_at) ? (NR'(1) << gid) : '0;
      ebusy = (c >= bstart && c <= bend);
      checks++;
      if (bus.en_code !== en || bus.grant_id !== GW'(gid)) begin
        errors++;
        $display("FAIL rnd_en_gid c=%0d got %0d/%0d want %0d/%0d",
                 c, bus.en_code, bus.grant_id, en, gid);
      end
      checks++;
      if (bus.cap_data !== cap || bus.busy !== ebusy) begin
        errors++;
        $display("FAIL rnd_cap_busy c=%0d got %0h/%b want %0h/%b",
                 c, bus.cap_data, bus.busy, cap, ebusy);
      end
      checks++;
      if (bus.req_ack !== eack) begin
        errors++;
        $display("FAIL rnd_ack c=%0d got %b want %b", c, bus.req_ack, eack);
      end
      pend &= ~ack_prev;
      for (int i = 0; i < NR; i++) begin
        if (ebusy && i == gid) begin
          if ($urandom_range(3) == 0) d[i*DW +: DW] = ~d[i*DW +: DW];
          if ($urandom_range(7) == 0) pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          d[i*DW +: DW] = DW'($urandom);
        end
      end
      if (c >= next_free && pend != '0) begin
        gid = pick(pend, ptr);
        cap = d[gid*DW +: DW];
        en = en + 5'd1;
        bstart = c + 1;
        bend = c + 1 + HC;
        ack_at = c + 1 + HC;
        next_free = c + 2 + HC;
        ptr = (gid + 1) % NR;
      end
      ack_prev = eack;
      bus.req_valid = pend;
      bus.req_data = d;
      step();
    end
    bus.req_valid = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_prio_pattern();
    test_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
